// File: rtl/fetch_queue_unit_pkg.sv
// fetch_queue_unit_pkg: constants and the fetch entry type shared by
// the fetch queue unit and its FIFO. No ports.
package fetch_queue_unit_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [63:0] RESET_PC_DEF  = 64'h0;
    localparam logic [63:0] PC_STEP       = 64'd4;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// fetch_queue_fifo: DEPTH-entry FIFO of fetch entries with flush.
// Ports: clk_i, rst_ni, push_i, pop_i, flush_i, data_i, count_o, head_o.
module fetch_queue_fifo
    import fetch_queue_unit_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  fetch_entry_t  data_i,
    output logic [CW-1:0] count_o,
    output fetch_entry_t  head_o
);

    localparam int unsigned   PW   = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is only allowed when a pop frees a slot
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != FULL) || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wr_q] <= data_i;
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: sequential-PC fetch front end owning the IF/ID register.
// Ports: clk, reset (async, low), redirect_*, stall_in, imem_req_*,
// imem_resp_*, if_id_* outputs and queue_count.
module fetch_queue_unit
    import fetch_queue_unit_pkg::*;
#(
    parameter logic [63:0] RESET_PC  = RESET_PC_DEF,
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     redirect_valid,
    input  logic [63:0]              redirect_pc,
    input  logic                     stall_in,
    output logic                     imem_req_valid,
    output logic [63:0]              imem_req_addr,
    input  logic                     imem_req_ready,
    input  logic                     imem_resp_valid,
    input  logic [31:0]              imem_resp_data,
    output logic                     if_id_valid,
    output logic [63:0]              if_id_pc,
    output logic [31:0]              if_id_instruction,
    output logic [$clog2(DEPTH):0]   queue_count
);

    localparam int unsigned   CW      = $clog2(DEPTH) + 1;
    localparam int unsigned   SW      = CW + 1;
    localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

    logic [63:0]   fetch_pc_q, fetch_pc_d;
    logic [63:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_q, drop_d;
    logic          if_valid_q, if_valid_d;
    logic [63:0]   if_pc_q, if_pc_d;
    logic [31:0]   if_instr_q, if_instr_d;

    logic          issue;
    logic          resp;
    logic          push;
    logic          pop;
    logic          flush;
    logic [CW-1:0] count;
    fetch_entry_t  push_entry;
    fetch_entry_t  head;
    logic [SW-1:0] occupancy;

    // In-flight plus queued fetches never exceed DEPTH, so a push
    // always has a slot waiting for it
    assign occupancy      = {1'b0, inflight_q} + {1'b0, count};
    assign imem_req_valid = reset && !redirect_valid
                            && (occupancy < DEPTH_S);
    assign imem_req_addr  = fetch_pc_q;
    assign issue          = imem_req_valid && imem_req_ready;

    // Responses with nothing outstanding (e.g. after reset) are ignored
    assign resp = imem_resp_valid && (inflight_q != '0);

    assign push_entry = '{pc: resp_pc_q, instr: imem_resp_data};

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        inflight_d = inflight_q + CW'(issue) - CW'(resp);
        drop_d     = drop_q;
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        push       = 1'b0;
        pop        = 1'b0;
        flush      = 1'b0;

        if (issue) fetch_pc_d = fetch_pc_q + PC_STEP;

        if (redirect_valid) begin
            // Everything still outstanding after this edge belongs to
            // the old path; a response arriving now is dropped too
            flush      = 1'b1;
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_d     = inflight_q - CW'(resp);
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end else begin
            if (resp) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push      = 1'b1;
                    resp_pc_d = resp_pc_q + PC_STEP;
                end
            end
            if (!stall_in) begin
                if (count != '0) begin
                    pop        = 1'b1;
                    if_valid_d = 1'b1;
                    if_pc_d    = head.pc;
                    if_instr_d = head.instr;
                end else begin
                    if_valid_d = 1'b0;
                    if_instr_d = NOP_INSTR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_q     <= '0;
            if_valid_q <= 1'b0;
            if_pc_q    <= '0;
            if_instr_q <= NOP_INSTR;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    fetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (push_entry),
        .count_o (count),
        .head_o  (head)
    );

    assign if_id_valid       = if_valid_q;
    assign if_id_pc          = if_pc_q;
    assign if_id_instruction = if_instr_q;
    assign queue_count       = count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: randomized and directed bench with a queue-based
// reference model and a latency-configurable in-order memory.
module tb_fetch_queue_unit;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] ins;
    } ent_t;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        stall_in;
    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        if_id_valid;
    logic [63:0] if_id_pc;
    logic [31:0] if_id_instruction;
    logic [2:0]  queue_count;

    fetch_queue_unit #(
        .RESET_PC  (64'h0),
        .DEPTH     (DEPTH),
        .NOP_INSTR (NOP)
    ) dut (
        .clk               (clk),
        .reset             (rst_n),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .stall_in          (stall_in),
        .imem_req_valid    (imem_req_valid),
        .imem_req_addr     (imem_req_addr),
        .imem_req_ready    (imem_req_ready),
        .imem_resp_valid   (imem_resp_valid),
        .imem_resp_data    (imem_resp_data),
        .if_id_valid       (if_id_valid),
        .if_id_pc          (if_id_pc),
        .if_id_instruction (if_id_instruction),
        .queue_count       (queue_count)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int errors = 0;

    // memory model
    mreq_t mq[$];
    int    lat = 1;
    int    cyc = 0;

    // reference model
    ent_t        fq[$];
    logic [63:0] m_fetch, m_resp, m_pc;
    int          m_inflight, m_drop;
    bit          m_v;
    logic [31:0] m_ins;

    // observation log
    logic [63:0] seen[$];
    int          first_v;
    logic [31:0] first_ins;
    int          cyc0;

    function automatic logic [31:0] instr_of(logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0001;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h (cyc %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        m_fetch    = 64'h0;
        m_resp     = 64'h0;
        m_pc       = 64'h0;
        m_inflight = 0;
        m_drop     = 0;
        m_v        = 1'b0;
        m_ins      = NOP;
    endtask

    task automatic model_step(input bit st, input bit rd,
                              input logic [63:0] rpc, input bit iss,
                              input bit rv, input logic [31:0] rdata);
        bit   r;
        ent_t e;
        r = rv && (m_inflight > 0);
        if (iss) begin
            m_inflight++;
            m_fetch += 64'd4;
        end
        if (r) m_inflight--;
        if (rd) begin
            fq.delete();
            m_v     = 1'b0;
            m_ins   = NOP;
            m_fetch = rpc;
            m_resp  = rpc;
            m_drop  = m_inflight;
        end else begin
            if (!st) begin
                if (fq.size() > 0) begin
                    e     = fq.pop_front();
                    m_v   = 1'b1;
                    m_pc  = e.pc;
                    m_ins = e.ins;
                end else begin
                    m_v   = 1'b0;
                    m_ins = NOP;
                end
            end
            if (r) begin
                if (m_drop > 0) begin
                    m_drop--;
                end else begin
                    fq.push_back('{pc: m_resp, ins: rdata});
                    m_resp += 64'd4;
                end
            end
        end
    endtask

    task automatic check_regs();
        chk("if_id_valid", 64'(if_id_valid), 64'(m_v));
        chk("if_id_instr", 64'(if_id_instruction), 64'(m_ins));
        if (m_v) chk("if_id_pc", if_id_pc, m_pc);
        chk("queue_count", 64'(queue_count), 64'(fq.size()));
        tests++;
        assert (queue_count <= 3'(DEPTH)) else begin
            errors++;
            $display("FAIL overflow: count %0d", queue_count);
        end
        if (m_inflight + fq.size() > DEPTH) begin
            errors++;
            $display("FAIL occupancy: %0d", m_inflight + fq.size());
        end
        if (if_id_valid === 1'b1) begin
            seen.push_back(if_id_pc);
            if (first_v < 0) begin
                first_v   = cyc - cyc0;
                first_ins = if_id_instruction;
            end
        end
    endtask

    task automatic cycle(input bit st, input bit rd,
                         input logic [63:0] rpc, input bit rdy);
        bit          iss, rv, exp_req;
        logic [31:0] rdata;
        mreq_t       t;
        check_regs();
        stall_in       = st;
        redirect_valid = rd;
        redirect_pc    = rpc;
        imem_req_ready = rdy;
        rv             = 1'b0;
        rdata          = '0;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            t     = mq.pop_front();
            rv    = 1'b1;
            rdata = instr_of(t.addr);
        end
        imem_resp_valid = rv;
        imem_resp_data  = rdata;
        #1;
        exp_req = !rd && (m_inflight + fq.size() < DEPTH);
        chk("req_valid", 64'(imem_req_valid), 64'(exp_req));
        if (exp_req) chk("req_addr", imem_req_addr, m_fetch);
        iss = exp_req && rdy;
        if (iss) mq.push_back('{addr: m_fetch, due: cyc + lat});
        model_step(st, rd, rpc, iss, rv, rdata);
        cyc++;
        @(negedge clk);
    endtask

    task automatic fill_to(input int n);
        int k;
        k = 0;
        while (fq.size() != n && k < 40) begin
            cycle(1'b1, 1'b0, 64'h0, 1'b1);
            k++;
        end
        chk("fill_reached", 64'(fq.size()), 64'(n));
    endtask

    task automatic check_path(input string nm, input logic [63:0] base);
        tests++;
        if (seen.size() < 2) begin
            errors++;
            $display("FAIL %s: only %0d valid", nm, seen.size());
        end else begin
            chk({nm, "_0"}, seen[0], base);
            chk({nm, "_1"}, seen[1], base + 64'd4);
        end
        foreach (seen[i]) begin
            if (seen[i] < base) begin
                errors++;
                $display("FAIL %s_stale: got %h want >=%h",
                         nm, seen[i], base);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] rpc;
        int          k;
        rst_n           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        stall_in        = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        first_v         = -1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_valid", 64'(if_id_valid), 64'h0);
        chk("rst_pc", if_id_pc, 64'h0);
        chk("rst_instr", 64'(if_id_instruction), 64'(NOP));
        chk("rst_count", 64'(queue_count), 64'h0);
        chk("rst_req", 64'(imem_req_valid), 64'h0);

        // straight-line fetch, 1-cycle memory
        rst_n = 1'b1;
        cyc0  = cyc;
        lat   = 1;
        repeat (12) cycle(1'b0, 1'b0, 64'h0, 1'b1);
        chk("first_valid_cycle", 64'(first_v), 64'd3);
        chk("first_instr", 64'(first_ins), 64'(instr_of(64'h0)));
        chk("seq_pc0", seen[0], 64'h0);
        chk("seq_pc1", seen[1], 64'h4);

        // decode stall saturates the queue
        repeat (6) cycle(1'b1, 1'b0, 64'h0, 1'b1);
        stall_in = 1'b1;
        #1;
        chk("stall_count", 64'(queue_count), 64'd4);
        chk("stall_req", 64'(imem_req_valid), 64'h0);
        chk("stall_hold", 64'(if_id_valid), 64'h1);
        repeat (10) cycle(1'b0, 1'b0, 64'h0, 1'b1);

        // redirect with stale fetches in flight
        lat = 3;
        repeat (6) cycle(1'b0, 1'b0, 64'h0, 1'b1);
        cycle(1'b0, 1'b1, 64'h100, 1'b1);
        seen.delete();
        repeat (12) cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_path("redir100", 64'h100);

        // redirect while stalled with 3 queued
        lat = 1;
        cycle(1'b0, 1'b1, 64'h180, 1'b1);
        fill_to(3);
        cycle(1'b1, 1'b1, 64'h1C0, 1'b1);
        chk("rs_count", 64'(queue_count), 64'h0);
        chk("rs_valid", 64'(if_id_valid), 64'h0);
        seen.delete();
        repeat (10) cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_path("redir1c0", 64'h1C0);

        // two redirects one cycle apart
        lat = 2;
        repeat (4) cycle(1'b0, 1'b0, 64'h0, 1'b1);
        cycle(1'b0, 1'b1, 64'h200, 1'b1);
        seen.delete();
        cycle(1'b0, 1'b0, 64'h0, 1'b1);
        cycle(1'b0, 1'b1, 64'h300, 1'b1);
        repeat (12) cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_path("redir300", 64'h300);

        // PC wrap-around
        lat = 1;
        cycle(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 1'b1);
        repeat (10) cycle(1'b0, 1'b0, 64'h0, 1'b1);

        // randomized traffic
        for (int blk = 0; blk < 4; blk++) begin
            lat = blk + 1;
            for (int i = 0; i < 150; i++) begin
                rpc      = {32'h0, $urandom()};
                rpc[1:0] = 2'b00;
                cycle($urandom_range(0, 99) < 30,
                      $urandom_range(0, 99) < 5,
                      rpc,
                      $urandom_range(0, 99) < 70);
            end
        end

        // asynchronous reset mid-stream
        lat = 3;
        cycle(1'b0, 1'b1, 64'h400, 1'b1);
        fill_to(3);
        rst_n           = 1'b0;
        stall_in        = 1'b0;
        redirect_valid  = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        #1;
        chk("arst_valid", 64'(if_id_valid), 64'h0);
        chk("arst_pc", if_id_pc, 64'h0);
        chk("arst_instr", 64'(if_id_instruction), 64'(NOP));
        chk("arst_count", 64'(queue_count), 64'h0);
        chk("arst_req", 64'(imem_req_valid), 64'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        k = 0;
        while (mq.size() > 0 && k < 40) begin
            cycle(1'b0, 1'b0, 64'h0, 1'b0);
            k++;
        end
        chk("stale_drained", 64'(mq.size()), 64'h0);
        seen.delete();
        repeat (10) cycle(1'b0, 1'b0, 64'h0, 1'b1);
        check_path("post_reset", 64'h0);
        chk("post_reset_instr", 64'(if_id_instruction),
            64'(m_ins));

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
